// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-seg scan of a short trail of animated positions
// Ports: clk_i/rst_i (sync active-high reset); overflow_i strobe captures
// {curr_display,row,column} into the trail; an_o active-low anodes, seg_o
// active-low {g..a}, dp_o active-low decimal point (held off).
module seg_scan_driver #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = 6,
  parameter int SCAN_DIV        = 4,
  parameter int BLANK_CYCLES    = 1,
  parameter int TRAIL_LEN       = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       overflow_i,
  input  logic [2:0]                 curr_display,
  input  logic                       row,
  input  logic [COL_WIDTH-1:0]       column,
  output logic [NUM_OF_DISPLAYS-1:0] an_o,
  output logic [6:0]                 seg_o,
  output logic                       dp_o
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [9:0]                 r_hist [TRAIL_LEN];
  logic [CW-1:0]              r_c, w_c;
  logic [2:0]                 r_d, w_d;
  logic [5:0]                 w_pat;
  logic                       w_valid, w_wrap;
  logic [NUM_OF_DISPLAYS-1:0] r_an;
  logic [6:0]                 r_seg;
  always_comb begin
    w_valid = row && column != '0 && (column & (column - COL_WIDTH'(1))) == '0
              && {1'b0, curr_display} < 4'(NUM_OF_DISPLAYS);
    w_wrap  = r_c == CW'(SCAN_DIV - 1);
    w_c     = w_wrap ? '0 : r_c + CW'(1);
    w_d     = !w_wrap ? r_d : r_d == 3'(NUM_OF_DISPLAYS - 1) ? 3'd0 : r_d + 3'd1;
    w_pat   = '0;
    for (int i = 0; i < TRAIL_LEN; i++)
      if (r_hist[i][9] && r_hist[i][8:6] == w_d) w_pat |= r_hist[i][5:0];
  end
  // Reset parks the scan on the last cycle of the last digit, so the first
  // released edge wraps into digit 0, cycle 0 and latches its pattern.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TRAIL_LEN; i++) r_hist[i] <= '0;
      r_c   <= CW'(SCAN_DIV - 1);
      r_d   <= 3'(NUM_OF_DISPLAYS - 1);
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else begin
      if (overflow_i) begin
        for (int i = TRAIL_LEN - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= {w_valid, curr_display, column};
      end
      r_c  <= w_c;
      r_d  <= w_d;
      r_an <= w_c < CW'(BLANK_CYCLES) ? '1 : ~(NUM_OF_DISPLAYS'(1) << w_d);
      if (w_c == '0) r_seg <= {1'b1, ~w_pat};
    end
  end
  assign an_o  = r_an;
  assign seg_o = r_seg;
  assign dp_o  = 1'b1;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench against a time-based reference model
module tb_seg_scan_driver;
  localparam int N = 6, SD = 4, BL = 1, TL = 3;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, ov = 0, row = 0;
  logic [2:0] disp = 0;
  logic [5:0] col = 0;
  logic [N-1:0] an;
  logic [6:0] seg;
  logic dp;
  seg_scan_driver dut (
    .clk_i(clk), .rst_i(rst), .overflow_i(ov), .curr_display(disp), .row(row),
    .column(col), .an_o(an), .seg_o(seg), .dp_o(dp)
  );
  typedef struct {bit v; int d; logic [5:0] s;} ent_t;
  typedef struct {logic [N-1:0] an; logic [6:0] seg;} exp_t;
  ent_t hist[$];
  exp_t sb[$];
  int t = -1, total = 0, bad = 0;
  logic [6:0] m_seg = 7'h7F;
  function automatic logic [5:0] pat(int dd);
    logic [5:0] p = 0;
    foreach (hist[k]) if (hist[k].v && hist[k].d == dd) p |= hist[k].s;
    return p;
  endfunction
  // t counts cycles since release; slot and digit follow from plain division.
  task automatic step(bit r, bit o, int dd, bit rw, logic [5:0] cc);
    int c, d;
    @(negedge clk);
    rst = r; ov = o; disp = 3'(dd); row = rw; col = cc;
    @(posedge clk);
    if (r) begin
      hist.delete();
      t = -1;
      m_seg = 7'h7F;
      sb.push_back('{an: {N{1'b1}}, seg: 7'h7F});
    end else begin
      t++;
      c = t % SD;
      d = (t / SD) % N;
      if (c == 0) m_seg = {1'b1, ~pat(d)};
      if (o) begin
        hist.push_front('{v: rw && $countones(cc) == 1 && dd < N, d: dd, s: cc});
        if (hist.size() > TL) void'(hist.pop_back());
      end
      sb.push_back('{an: c < BL ? {N{1'b1}} : ~(N'(1) << d), seg: m_seg});
    end
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask
  // Advance until the next edge enters cycle 0 of digit td.
  task automatic to_slot_start(int td);
    int k = 0;
    while (!((t + 1) % SD == 0 && ((t + 1) / SD) % N == td) && k < 200) begin
      idle(1);
      k++;
    end
    if (k == 200) begin
      total++; bad++;
      $display("FAIL slot_wait: never reached digit %0d start", td);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (an !== e.an || seg !== e.seg || dp !== 1'b1) begin
        bad++;
        $display("FAIL scan t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 t, an, seg, dp, e.an, e.seg);
      end
    end
  end
  initial begin
    int k;
    repeat (3) step(1, 0, 0, 0, 0);
    idle(30);
    step(0, 1, 2, 1, 6'b000001);
    idle(50);
    foreach (col[b]) if (b < 4) begin
      step(0, 1, 0, 1, 6'(1 << b));
      idle(2);
    end
    idle(30);
    step(0, 1, 4, 1, 6'b100000);
    idle(3);
    step(0, 1, 4, 1, 6'b000011);
    idle(3);
    step(0, 1, 7, 1, 6'b000100);
    idle(3);
    step(0, 1, 4, 0, 6'b100000);
    idle(30);
    to_slot_start(3);
    step(0, 1, 3, 1, 6'b010000);
    idle(50);
    step(0, 1, 2, 1, 6'b000100);
    k = 0;
    while (!(t % SD == 2 && (t / SD) % N == 2) && k < 200) begin
      idle(1);
      k++;
    end
    if (k == 200) begin
      total++; bad++;
      $display("FAIL reset_wait: never reached digit 2 active");
    end
    step(1, 0, 0, 0, 0);
    idle(30);
    repeat (3000)
      step(($urandom % 200) == 0, ($urandom % 4) == 0, $urandom_range(0, 7),
           ($urandom % 5) != 0,
           ($urandom % 2) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom));
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
